seq_10000001_detector: RTL and testbench



---
 rtl/seq_10000001_detector_pkg.sv | 16 +
 rtl/seq_10000001_detector.sv | 32 +++
 tb/tb_seq_10000001_detector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_10000001_detector_pkg.sv
// seq_10000001_detector_pkg: state encoding and pattern constant for the 10000001 detector
package seq_10000001_detector_pkg;
    localparam int STATE_W = 4;
    localparam logic [7:0] PATTERN = 8'b10000001;
    typedef enum logic [STATE_W-1:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;
endpackage

// File: rtl/seq_10000001_detector.sv
// seq_10000001_detector: Moore FSM flagging each overlapping 10000001 in a serial bit stream
module seq_10000001_detector
    import seq_10000001_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic J,
    output logic Y
);
    state_t state, state_next;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S0;
        else     state <= state_next;
    end
    // Codes 9..15 fall to the default and recover to idle
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = J ? S1 : S0;
            S1:      state_next = J ? S1 : S2;
            S2:      state_next = J ? S1 : S3;
            S3:      state_next = J ? S1 : S4;
            S4:      state_next = J ? S1 : S5;
            S5:      state_next = J ? S1 : S6;
            S6:      state_next = J ? S1 : S7;
            S7:      state_next = J ? S8 : S0;
            S8:      state_next = J ? S1 : S2;
            default: state_next = S0;
        endcase
    end
    always_comb Y = (state == S8);
endmodule

// File: tb/tb_seq_10000001_detector.sv
// tb_seq_10000001_detector: randomized and directed checks against a sliding-window model
module tb_seq_10000001_detector;
    import seq_10000001_detector_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic J = 1'b0;
    logic Y;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic exp_y = 1'b0;
    logic [7:0] pat = PATTERN;
    bit hist[$];

    always #5 clk = ~clk;

    seq_10000001_detector dut (.clk(clk), .rst(rst), .J(J), .Y(Y));

    // Expected flag: last eight samples since reset equal the pattern, oldest first
    function automatic logic window_match();
        if (hist.size() != 8) return 1'b0;
        for (int i = 0; i < 8; i++)
            if (hist[i] != pat[7-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input logic b);
        J = b;
        @(posedge clk);
        edge_n++;
        if (rst) hist.delete();
        else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        exp_y = rst ? 1'b0 : window_match();
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (Y !== 1'b0) begin errors++; $display("FAIL reset_initial Y=%b expected 0", Y); end
        for (int i = 0; i < 4; i++) begin
            drive(i[0]);
            checks++;
            if (Y !== 1'b0) begin errors++; $display("FAIL reset_hold cycle %0d Y=%b expected 0", i, Y); end
        end
        rst = 1'b0;
        hist.delete();
        #1;
        checks++;
        if (Y !== 1'b0) begin errors++; $display("FAIL reset_release Y=%b expected 0", Y); end
    endtask

    int first_pulse;

    task automatic test_basic();
        logic seq [15] = '{0,1,0,0,1,0,1,1,0,0,0,0,0,0,1};
        int pulses = 0;
        for (int i = 0; i < 15; i++) begin
            drive(seq[i]);
            checks++;
            if (Y !== exp_y) begin errors++; $display("FAIL basic cycle %0d Y=%b expected %b", i, Y, exp_y); end
            if (Y === 1'b1) begin pulses++; first_pulse = edge_n; end
        end
        checks++;
        if (pulses != 1 || Y !== 1'b1) begin
            errors++; $display("FAIL basic_count pulses=%0d lastY=%b expected 1 pulse at final bit", pulses, Y);
        end
    endtask

    task automatic test_overlap();
        int pulse_at = -1;
        for (int i = 0; i < 7; i++) begin
            drive(i == 6);
            checks++;
            if (Y !== exp_y) begin errors++; $display("FAIL overlap cycle %0d Y=%b expected %b", i, Y, exp_y); end
            if (Y === 1'b1) pulse_at = edge_n;
        end
        checks++;
        if (pulse_at - first_pulse != 7) begin
            errors++; $display("FAIL overlap_spacing gap=%0d expected 7", pulse_at - first_pulse);
        end
    endtask

    task automatic test_near_miss();
        logic seq [26] = '{1,0,0,0,0,0,0,0,1, 1,0,0,0,0,0,1, 1,1,1,1,1,1,1,1,1,1};
        int pulses = 0;
        for (int i = 0; i < 26; i++) begin
            drive(seq[i]);
            checks++;
            if (Y !== exp_y) begin errors++; $display("FAIL near_miss cycle %0d Y=%b expected %b", i, Y, exp_y); end
            if (Y === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL near_miss_count pulses=%0d expected 0", pulses); end
    endtask

    task automatic test_recovery();
        logic seq [23] = '{1,0,0,0,0,0,0,1, 0,0,1,1,0,0,0,1,0,0,0,0,0,0,1};
        int pulses = 0;
        for (int i = 0; i < 23; i++) begin
            drive(seq[i]);
            checks++;
            if (Y !== exp_y) begin errors++; $display("FAIL recovery cycle %0d Y=%b expected %b", i, Y, exp_y); end
            if (Y === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2 || Y !== 1'b1) begin
            errors++; $display("FAIL recovery_count pulses=%0d lastY=%b expected 2 with final high", pulses, Y);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) drive(i == 0 || i == 7);
        checks++;
        if (Y !== 1'b1) begin errors++; $display("FAIL async_pre Y=%b expected 1", Y); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (Y !== 1'b0 || dut.state !== S0) begin
            errors++; $display("FAIL async_mid_high Y=%b state=%0d expected 0/0", Y, dut.state);
        end
        #1 rst = 1'b0;
        hist.delete();
        for (int i = 0; i < 7; i++) drive(i == 0);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dut.state !== S0) begin errors++; $display("FAIL async_state state=%0d expected 0", dut.state); end
        #1 rst = 1'b0;
        hist.delete();
        drive(1'b1);
        checks++;
        if (Y !== 1'b0 || Y !== exp_y) begin errors++; $display("FAIL async_discard Y=%b expected 0", Y); end
    endtask

    task automatic test_random();
        int pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 4) == 0);
            checks++;
            if (Y !== exp_y) begin errors++; $display("FAIL random cycle %0d Y=%b expected %b", i, Y, exp_y); end
            if (exp_y) pulses++;
        end
        checks++;
        if (pulses == 0) begin errors++; $display("FAIL random_coverage matches=%0d expected >0", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_recovery();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
